dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 148 ++++++++++++++
 tb/tb_dmem_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Memory-side end of the processor DMEM port: big-endian, byte-addressed, word-organised
// storage with combinational loads, lane-merged synchronous stores and a post-reset clear sweep.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_WIDTH   = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [0:31] addr,
    input  logic        write_enable,
    input  logic        byte_access,
    input  logic        half_word,
    input  logic        sign_extend,
    input  logic [0:31] data_in,
    output logic [0:31] data_out,
    output logic        ready,
    output logic        misalign_err,
    output logic [0:31] err_addr,
    output logic [0:31] store_count
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]           state_reg;
    logic [IDX_WIDTH-1:0] clear_ptr_reg;
    logic                 misalign_err_reg;
    logic [0:31]          err_addr_reg;
    logic [0:31]          store_count_reg;

    logic [29:0]          idx;
    logic [IDX_WIDTH-1:0] mem_idx;
    logic [1:0]           lane_b;
    logic                 lane_h;
    logic                 in_range;
    logic                 is_byte;
    logic                 is_half;
    logic                 is_word;
    logic                 misaligned;
    logic                 access_ok;
    logic                 store_ok;
    logic [0:31]          rd_word;
    logic [0:7]           byte_val;
    logic [0:15]          half_val;
    logic [0:31]          rd_data;

    assign idx      = addr[0:29];
    assign mem_idx  = idx[IDX_WIDTH-1:0];
    assign lane_b   = addr[30:31];
    assign lane_h   = addr[30];
    assign in_range = (idx < 30'(DEPTH_WORDS));

    // byte wins over half_word; neither selects a full word
    assign is_byte = byte_access;
    assign is_half = !byte_access && half_word;
    assign is_word = !byte_access && !half_word;

    assign misaligned = (is_half && addr[31]) || (is_word && (addr[30:31] != 2'b00));
    assign access_ok  = in_range && !misaligned;
    assign store_ok   = !reset && (state_reg == ST_READY) && write_enable && access_ok;

    // One narrow memory per byte lane so partial stores need no read-modify-write.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic       lane_sel;
            logic [7:0] wr_data;

            assign lane_sel = is_word
                           || (is_half && (lane_h == 1'(gi / 2)))
                           || (is_byte && (lane_b == 2'(gi)));

            always_comb begin
                wr_data = data_in[24:31];
                if (is_word) begin
                    wr_data = data_in[8*gi +: 8];
                end else if (is_half) begin
                    wr_data = data_in[16 + 8*(gi % 2) +: 8];
                end
            end

            always_ff @(posedge clock) begin
                if (state_reg == ST_CLEAR) begin
                    lane_mem[clear_ptr_reg] <= 8'h00;
                end else if (store_ok && lane_sel) begin
                    lane_mem[mem_idx] <= wr_data;
                end
            end

            assign rd_word[8*gi +: 8] = lane_mem[mem_idx];
        end
    endgenerate

    assign byte_val = rd_word[8*lane_b +: 8];
    assign half_val = rd_word[16*lane_h +: 16];

    always_comb begin
        rd_data = '0;
        if ((state_reg == ST_READY) && access_ok) begin
            if (is_byte) begin
                rd_data = {{24{sign_extend & byte_val[0]}}, byte_val};
            end else if (is_half) begin
                rd_data = {{16{sign_extend & half_val[0]}}, half_val};
            end else begin
                rd_data = rd_word;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= ST_CLEAR;
            clear_ptr_reg    <= '0;
            misalign_err_reg <= 1'b0;
            err_addr_reg     <= '0;
            store_count_reg  <= '0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    clear_ptr_reg <= clear_ptr_reg + 1'b1;
                    if (clear_ptr_reg == IDX_WIDTH'(DEPTH_WORDS - 1)) begin
                        state_reg <= ST_READY;
                    end
                end
                ST_READY: begin
                    // out-of-range accesses are ignored entirely, including alignment
                    if (in_range && misaligned) begin
                        misalign_err_reg <= 1'b1;
                        if (!misalign_err_reg) begin
                            err_addr_reg <= addr;
                        end
                    end
                    if (store_ok) begin
                        store_count_reg <= store_count_reg + 32'd1;
                    end
                end
                default: state_reg <= ST_CLEAR;
            endcase
        end
    end

    assign data_out     = rd_data;
    assign ready        = (state_reg == ST_READY);
    assign misalign_err = misalign_err_reg;
    assign err_addr     = err_addr_reg;
    assign store_count  = store_count_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a word-level reference model checked every cycle,
// plus literal expectations taken straight from the memory's behavioural rules.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic        clock;
    logic        reset;
    logic [0:31] addr;
    logic        write_enable;
    logic        byte_access;
    logic        half_word;
    logic        sign_extend;
    logic [0:31] data_in;
    logic [0:31] data_out;
    logic        ready;
    logic        misalign_err;
    logic [0:31] err_addr;
    logic [0:31] store_count;

    int checks   = 0;
    int failures = 0;
    int printed  = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .IDX_WIDTH(10)) dut (
        .clock        (clock),
        .reset        (reset),
        .addr         (addr),
        .write_enable (write_enable),
        .byte_access  (byte_access),
        .half_word    (half_word),
        .sign_extend  (sign_extend),
        .data_in      (data_in),
        .data_out     (data_out),
        .ready        (ready),
        .misalign_err (misalign_err),
        .err_addr     (err_addr),
        .store_count  (store_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (printed < 60) begin
                printed++;
                $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
            end
        end
    endtask

    // ---------------- reference model (whole words, numeric big-endian lanes) ----------------
    logic [31:0] mmem [DEPTH];
    bit          mvalid = 0;
    bit          mready;
    int          clr_cnt;
    logic        merr;
    logic [31:0] merr_addr;
    logic [31:0] mcount;

    function automatic bit mis_f(input logic [31:0] a, input bit b, input bit h);
        if (b) return 1'b0;
        if (h) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input bit b, input bit h, input bit s);
        logic [31:0] w;
        logic [31:0] v;
        if (!mready || (a / 4) >= DEPTH || mis_f(a, b, h)) return 32'h0;
        w = mmem[a / 4];
        if (b) begin
            v = (w >> (24 - 8 * a[1:0])) & 32'hFF;
            if (s && v[7]) v = v | 32'hFFFF_FF00;
        end else if (h) begin
            v = (w >> (16 - 16 * a[1])) & 32'hFFFF;
            if (s && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    always @(posedge clock) begin
        logic [31:0] a;
        logic [31:0] w;
        int          sh;
        a = addr;
        if (reset) begin
            mvalid    = 1;
            mready    = 0;
            clr_cnt   = 0;
            merr      = 0;
            merr_addr = 0;
            mcount    = 0;
        end else if (mvalid) begin
            if (!mready) begin
                clr_cnt++;
                if (clr_cnt == DEPTH) begin
                    mready = 1;
                    foreach (mmem[i]) mmem[i] = 32'h0;
                end
            end else if ((a / 4) < DEPTH) begin
                if (mis_f(a, byte_access, half_word)) begin
                    if (!merr) merr_addr = a;
                    merr = 1;
                end else if (write_enable) begin
                    w = mmem[a / 4];
                    if (byte_access) begin
                        sh = 24 - 8 * a[1:0];
                        w = (w & ~(32'hFF << sh)) | ((data_in & 32'hFF) << sh);
                    end else if (half_word) begin
                        sh = 16 - 16 * a[1];
                        w = (w & ~(32'hFFFF << sh)) | ((data_in & 32'hFFFF) << sh);
                    end else begin
                        w = data_in;
                    end
                    mmem[a / 4] = w;
                    mcount++;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (mvalid) begin
            check("cyc_data_out", data_out, exp_read(addr, byte_access, half_word, sign_extend));
            check("cyc_ready", 32'(ready), 32'(mready));
            check("cyc_misalign_err", 32'(misalign_err), 32'(merr));
            check("cyc_err_addr", err_addr, merr_addr);
            check("cyc_store_count", store_count, mcount);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input bit we, input bit b, input bit h,
                         input bit s, input logic [31:0] d);
        addr = a; write_enable = we; byte_access = b; half_word = h; sign_extend = s; data_in = d;
        $display("txn t=%0t addr=%h we=%0d byte=%0d half=%0d sext=%0d data=%h",
                 $time, a, we, b, h, s, d);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input bit b, input bit h, input logic [31:0] d);
        drive(a, 1, b, h, 0, d);
        cyc();
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input bit b, input bit h,
                          input bit s, input logic [31:0] exp);
        drive(a, 0, b, h, s, 32'h0);
        check(name, data_out, exp);
        cyc();
    endtask

    // Counts clocks spent with ready low; a stray store is attempted during the clear.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 3000) begin
            addr = 32'h10; write_enable = (n == 5); byte_access = 0; half_word = 0;
            sign_extend = 0; data_in = 32'hFFFF_FFFF;
            cyc();
            n++;
        end
        write_enable = 0;
        check("ready_timeout", 32'(n < 3000), 32'd1);
    endtask

    initial begin
        int n;
        reset = 1;
        drive(32'h0, 0, 0, 0, 0, 32'h0);
        cyc();
        cyc();
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_count", store_count, 32'd0);
        reset = 0;
        wait_ready(n);
        check("clear_cycles", 32'(n), 32'(DEPTH));
        check("count_after_clear", store_count, 32'd0);

        for (int i = 0; i < DEPTH; i++) begin
            drive(32'(i * 4), 0, 0, 0, 0, 32'h0);
            check("sweep_zero", data_out, 32'h0);
            cyc();
        end

        wr(32'h10, 0, 0, 32'h1122_3344);
        rd_chk("byte_10", 32'h10, 1, 0, 0, 32'h11);
        rd_chk("byte_11", 32'h11, 1, 0, 0, 32'h22);
        rd_chk("byte_12", 32'h12, 1, 0, 0, 32'h33);
        rd_chk("byte_13", 32'h13, 1, 0, 0, 32'h44);
        check("count_1", store_count, 32'd1);

        wr(32'h12, 1, 0, 32'h0000_00AB);
        rd_chk("word_after_byte", 32'h10, 0, 0, 0, 32'h1122_AB44);
        rd_chk("sbyte_12", 32'h12, 1, 0, 1, 32'hFFFF_FFAB);
        rd_chk("ubyte_12", 32'h12, 1, 0, 0, 32'h0000_00AB);
        rd_chk("shalf_10", 32'h10, 0, 1, 1, 32'h0000_1122);

        drive(32'h40, 1, 0, 0, 0, 32'hDEAD_BEEF);
        check("rdw_old", data_out, 32'h0);
        cyc();
        rd_chk("rdw_new", 32'h40, 0, 0, 0, 32'hDEAD_BEEF);
        check("count_3", store_count, 32'd3);

        wr(32'(DEPTH * 4), 0, 0, 32'h5555_5555);
        check("oor_count", store_count, 32'd3);
        check("oor_no_err", 32'(misalign_err), 32'd0);

        wr(32'h20, 0, 1, 32'h0000_8001);
        rd_chk("shalf_20", 32'h20, 0, 1, 1, 32'hFFFF_8001);
        rd_chk("uhalf_20", 32'h20, 0, 1, 0, 32'h0000_8001);
        rd_chk("word_20", 32'h20, 0, 0, 0, 32'h8001_0000);

        wr(32'h22, 0, 0, 32'h1234_5678);
        check("mis_err", 32'(misalign_err), 32'd1);
        check("mis_err_addr", err_addr, 32'h22);
        check("mis_count", store_count, 32'd4);
        rd_chk("word_20_kept", 32'h20, 0, 0, 0, 32'h8001_0000);
        rd_chk("mis_half_rd", 32'h31, 0, 1, 1, 32'h0);
        drive(32'h30, 0, 0, 0, 0, 32'h0);
        check("first_err_wins", err_addr, 32'h22);
        cyc();

        reset = 1;
        cyc();
        reset = 0;
        for (int i = 0; i < 100; i++) cyc();
        check("mid_clear_not_ready", 32'(ready), 32'd0);
        reset = 1;
        cyc();
        reset = 0;
        wait_ready(n);
        check("reclear_cycles", 32'(n), 32'(DEPTH));
        check("reclear_count", store_count, 32'd0);
        check("reclear_err", 32'(misalign_err), 32'd0);
        check("reclear_err_addr", err_addr, 32'h0);
        rd_chk("reclear_10", 32'h10, 0, 0, 0, 32'h0);
        rd_chk("reclear_40", 32'h40, 0, 0, 0, 32'h0);
        rd_chk("reclear_20", 32'h20, 0, 0, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
